// File: rtl/mux_share_arbiter_pkg.sv
// Shared types and constants for the four-way time-shared mux controller.
package mux_share_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

endpackage

// File: rtl/mux_share_arbiter_rr_pick4.sv
// Round-robin picker: first asserted request at or above ptr, wrapping 3 -> 0.
module rr_pick4
    import mux_share_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic [NUM_REQ-1:0] rot_s;
    logic [SEL_W-1:0]   off_s;

    // Rotate requests so bit 0 is the requester ptr points at.
    always_comb begin
        rot_s = req;
        case (ptr)
            2'd0:    rot_s = req;
            2'd1:    rot_s = {req[0],   req[3:1]};
            2'd2:    rot_s = {req[1:0], req[3:2]};
            2'd3:    rot_s = {req[2:0], req[3]};
            default: rot_s = req;
        endcase
    end

    // Priority-encode the rotated vector and undo the rotation.
    always_comb begin
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        winner = ptr + off_s;
        any    = |req;
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 4:1 output mux; holds the select for a bounded
// burst under a valid/ready handshake, with one idle cycle between bursts.
module mux_share_arbiter
    import mux_share_arbiter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          last,
    input  logic [NUM_REQ*DATA_W-1:0]   data_in,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy
);

    localparam int                 CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [SEL_W-1:0]     winner_s;
    logic                 any_s;
    logic                 xfer_s;
    logic                 cur_req_s;
    logic                 cur_last_s;
    logic                 accept_s;
    logic                 burst_end_s;
    logic [DATA_W-1:0]    mux_word_s;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner_s),
        .any    (any_s)
    );

    // DATA_W-wide 4:1 data mux driven by the registered select.
    always_comb begin
        mux_word_s = {DATA_W{1'b0}};
        case (sel_q)
            2'd0:    mux_word_s = data_in[0*DATA_W +: DATA_W];
            2'd1:    mux_word_s = data_in[1*DATA_W +: DATA_W];
            2'd2:    mux_word_s = data_in[2*DATA_W +: DATA_W];
            2'd3:    mux_word_s = data_in[3*DATA_W +: DATA_W];
            default: mux_word_s = {DATA_W{1'b0}};
        endcase
    end

    // Handshake and burst-termination decode for the current owner.
    always_comb begin
        xfer_s      = (state_q == ST_XFER);
        cur_req_s   = req[sel_q];
        cur_last_s  = last[sel_q];
        accept_s    = xfer_s & cur_req_s & out_ready;
        // A withdrawn request ends the burst without a beat.
        burst_end_s = xfer_s & (~cur_req_s | (accept_s & (cur_last_s | (cnt_q == CNT_LAST))));
    end

    // Next-state logic: arbitrate in IDLE, count beats and close bursts in XFER.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    state_d = ST_XFER;
                    sel_d   = winner_s;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (burst_end_s) begin
                    state_d = ST_IDLE;
                    grant_d = {NUM_REQ{1'b0}};
                    ptr_d   = sel_q + 2'd1;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (accept_s) begin
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_REQ{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            grant_q <= {NUM_REQ{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = xfer_s & cur_req_s;
    assign out_data  = xfer_s ? mux_word_s : {DATA_W{1'b0}};
    assign out_sel   = sel_q;
    assign grant     = grant_q;
    assign busy      = xfer_s;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of round-robin burst ownership.
module tb_mux_share_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [3:0]    last;
    logic [31:0]   data_in;
    logic          out_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [1:0]    out_sel;
    logic [3:0]    grant;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Model: who owns the channel, how many beats it has moved, where the search starts.
    bit m_busy;
    int m_owner, m_sel, m_ptr, m_beats;
    int beats_seen;

    mux_share_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data_in(data_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [31:0] e_data;
        e_data = m_busy ? 32'((data_in >> (m_owner * DW)) & 32'hFF) : 32'h0;
        chk("out_valid", 32'(out_valid), m_busy ? 32'(req[m_owner]) : 32'h0);
        chk("out_data",  32'(out_data),  e_data);
        chk("grant",     32'(grant),     m_busy ? (32'h1 << m_owner) : 32'h0);
        chk("out_sel",   32'(out_sel),   32'(m_sel));
        chk("busy",      32'(busy),      32'(m_busy));
        if (out_valid && out_ready) beats_seen++;
    endtask

    task automatic model_edge();
        int w;
        if (!rst_n) begin
            m_busy = 1'b0; m_ptr = 0; m_sel = 0; m_beats = 0; m_owner = 0;
        end else if (!m_busy) begin
            if (req != 4'b0000) begin
                w = 0;
                for (int k = 3; k >= 0; k--)
                    if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                m_busy = 1'b1; m_owner = w; m_sel = w; m_beats = 0;
            end
        end else begin
            if (!req[m_owner]) begin
                m_busy = 1'b0; m_ptr = (m_owner + 1) % 4;
            end else if (out_ready) begin
                m_beats++;
                if (last[m_owner] || m_beats == MB) begin
                    m_busy = 1'b0; m_ptr = (m_owner + 1) % 4;
                end
            end
        end
    endtask

    // One clock: drive at negedge, compare before the edge, advance the model at the edge.
    task automatic cyc(input logic rn, input logic [3:0] rq, input logic [3:0] ls,
                       input logic [31:0] d, input logic rdy);
        @(negedge clk);
        rst_n = rn; req = rq; last = ls; data_in = d; out_ready = rdy;
        #1;
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    logic [3:0] fair_exp [9];
    logic [31:0] rd;

    initial begin
        rst_n = 1'b0; req = 4'b0000; last = 4'b0000; data_in = 32'h0; out_ready = 1'b0;
        m_busy = 1'b0; m_owner = 0; m_sel = 0; m_ptr = 0; m_beats = 0; beats_seen = 0;

        // Reset state
        cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);

        // Reset mid-burst
        cyc(1'b1, 4'b0001, 4'b0000, 32'h000000A5, 1'b1);
        chk("mid_grant0", 32'(grant), 32'h1);
        chk("mid_data", 32'(out_data), 32'hA5);
        cyc(1'b1, 4'b0001, 4'b0000, 32'h000000A5, 1'b1);
        cyc(1'b0, 4'b0001, 4'b0000, 32'h000000A5, 1'b1);
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_grant", 32'(grant), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        cyc(1'b1, 4'b0001, 4'b0000, 32'h000000A5, 1'b1);
        chk("mid_regrant", 32'(grant), 32'h1);
        cyc(1'b1, 4'b0000, 4'b0000, 32'h000000A5, 1'b1);

        // Fairness: single-beat bursts rotate 0,1,2,3,0 with an idle cycle between
        cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        fair_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 4'b1111, 4'b1111, 32'h44332211, 1'b1);
            chk("fair_grant", 32'(grant), 32'(fair_exp[i]));
        end
        cyc(1'b1, 4'b0000, 4'b0000, 32'h44332211, 1'b1);

        // Burst cap: four beats from requester 2, then ptr lands on 3
        cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        cyc(1'b1, 4'b0100, 4'b0000, 32'h00C30000, 1'b1);
        beats_seen = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0100, 4'b0000, 32'h00C30000, 1'b1);
        chk("cap_beats", 32'(beats_seen), 32'd4);
        chk("cap_busy", 32'(busy), 32'h0);
        cyc(1'b1, 4'b1100, 4'b0000, 32'h00C30000, 1'b1);
        chk("cap_ptr3", 32'(grant), 32'h8);
        cyc(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);

        // Stall on requester 1: held beats are not counted
        cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        cyc(1'b1, 4'b0010, 4'b0000, 32'h00005A00, 1'b1);
        beats_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'b0010, 4'b0000, 32'h00005A00, 1'b0);
            chk("stall_data", 32'(out_data), 32'h5A);
            chk("stall_busy", 32'(busy), 32'h1);
        end
        chk("stall_beats", 32'(beats_seen), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0010, 4'b0000, 32'h00005A00, 1'b1);
        chk("stall_still", 32'(busy), 32'h1);
        cyc(1'b1, 4'b0010, 4'b0000, 32'h00005A00, 1'b1);
        chk("stall_end", 32'(busy), 32'h0);
        chk("stall_total", 32'(beats_seen), 32'd4);

        // Withdrawal by requester 3, then ptr wraps to 0
        cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        cyc(1'b1, 4'b1000, 4'b0000, 32'h7E000000, 1'b1);
        chk("wd_grant3", 32'(grant), 32'h8);
        cyc(1'b1, 4'b1000, 4'b0000, 32'h7E000000, 1'b1);
        cyc(1'b1, 4'b0000, 4'b0000, 32'h7E000000, 1'b1);
        chk("wd_idle", 32'(busy), 32'h0);
        cyc(1'b1, 4'b1001, 4'b0000, 32'h7E000011, 1'b1);
        chk("wd_wrap", 32'(grant), 32'h1);
        cyc(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);

        // Last and cap on the same beat: one transition, ptr advances once
        cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        cyc(1'b1, 4'b0001, 4'b0000, 32'h00000033, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0001, 4'b0000, 32'h00000033, 1'b1);
        cyc(1'b1, 4'b0001, 4'b0001, 32'h00000033, 1'b1);
        chk("sim_idle", 32'(busy), 32'h0);
        cyc(1'b1, 4'b0011, 4'b0000, 32'h00000033, 1'b1);
        chk("sim_ptr1", 32'(grant), 32'h2);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rd = $urandom;
            cyc(($urandom_range(0, 60) != 0),
                4'($urandom) | 4'(($urandom_range(0, 3) == 0) ? 4'hF : 4'h0),
                4'($urandom) & 4'($urandom),
                rd,
                ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
